// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// alu_seq_if : start/done request bus between the execute stage and alu_seq
// Revision   : 1.0
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             co;
  logic             zero;

  modport master (
    output start, sel, op1, op2,
    input  busy, done, out, co, zero
  );

  modport slave (
    input  start, sel, op1, op2,
    output busy, done, out, co, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq  : registered ALU with start/done handshake; iterative DIV and MUL
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

  localparam logic [2:0] C_ADD   = 3'b000;
  localparam logic [2:0] C_ASHL  = 3'b001;
  localparam logic [2:0] C_XNOR  = 3'b010;
  localparam logic [2:0] C_DIV   = 3'b011;
  localparam logic [2:0] C_PASS2 = 3'b100;
  localparam logic [2:0] C_PASS1 = 3'b101;
  localparam logic [2:0] C_NEG   = 3'b110;
  localparam logic [2:0] C_MUL   = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_out;
  logic               r_co;
  logic               r_zero;

  logic               w_multi;
  logic [WIDTH-1:0]   w_res;
  logic               w_co;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH:0]     w_psum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_fin_out;
  logic               w_fin_co;

  assign w_multi = (bus.sel == C_MUL) || ((bus.sel == C_DIV) && (bus.op2 != '0));
  assign w_sum   = {1'b0, bus.op1} + {1'b0, bus.op2};

  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    case (bus.sel)
      C_ADD:   begin w_res = w_sum[WIDTH-1:0]; w_co = w_sum[WIDTH]; end
      C_ASHL:  begin w_res = {bus.op2[WIDTH-2:0], 1'b0}; w_co = bus.op2[WIDTH-1]; end
      C_XNOR:  w_res = ~(bus.op1 ^ bus.op2);
      C_DIV:   begin w_res = '1; w_co = 1'b1; end
      C_PASS2: w_res = bus.op2;
      C_PASS1: w_res = bus.op1;
      C_NEG:   w_res = (~bus.op2) + 1'b1;
      default: begin w_res = '0; w_co = 1'b0; end
    endcase
  end

  // Restoring divide: shift next dividend bit in, subtract if it fits.
  // r_rem[WIDTH] stays 0 for a restoring divider but keeps the compare exact.
  always_comb begin
    w_trial   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_ge      = r_rem[WIDTH] || (w_trial >= {1'b0, r_opb});
    w_rem_nxt = w_ge ? (w_trial - {1'b0, r_opb}) : w_trial;
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  end

  // Shift-add multiply: multiplier sits in the low half and shifts out LSB-first.
  always_comb begin
    w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};
    w_fin_out  = r_mul ? w_prod_nxt[WIDTH-1:0] : w_quo_nxt;
    w_fin_co   = r_mul ? (w_prod_nxt[2*WIDTH-1:WIDTH] != '0) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul   <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_opb   <= '0;
      r_prod  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_co    <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_multi) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= C_CNT_LOAD;
              r_mul   <= (bus.sel == C_MUL);
              r_opb   <= bus.op2;
              r_rem   <= '0;
              r_quo   <= bus.op1;
              r_prod  <= {{WIDTH{1'b0}}, bus.op1};
            end else begin
              r_out  <= w_res;
              r_co   <= w_co;
              r_zero <= (w_res == '0);
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cnt  <= r_cnt - 1'b1;
          r_rem  <= w_rem_nxt;
          r_quo  <= w_quo_nxt;
          r_prod <= w_prod_nxt;
          if (r_cnt == C_CNT_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_out   <= w_fin_out;
            r_co    <= w_fin_co;
            r_zero  <= (w_fin_out == '0);
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.co   = r_co;
  assign bus.zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : scoreboard bench for alu_seq, directed cases plus random traffic
// Revision   : 1.0
// ============================================================================
module tb_alu_seq;
  localparam int W  = 8;
  localparam int W2 = 2 * W;

  typedef struct {
    logic [W-1:0] out;
    logic         co;
    logic         zero;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   edge_cnt = 0;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   busy_end = 0;
  exp_t q[$];
  exp_t mon_x;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain arithmetic on the operation rules, returns {co, out}.
  function automatic logic [W:0] ref_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W2-1:0] wide;
    logic [W-1:0]  r;
    logic          c;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    case (s)
      3'd0: begin wide = W2'(a) + W2'(b); r = wide[W-1:0]; c = (wide >> W) != 0; end
      3'd1: begin wide = W2'(b) * 2;      r = wide[W-1:0]; c = (wide >> W) != 0; end
      3'd2: r = ~(a ^ b);
      3'd3: if (b == 0) begin r = '1; c = 1'b1; end else r = a / b;
      3'd4: r = b;
      3'd5: r = a;
      3'd6: begin wide = (W2'(1) << W) - W2'(b); r = wide[W-1:0]; end
      default: begin wide = W2'(a) * W2'(b); r = wide[W-1:0]; c = (wide >> W) != 0; end
    endcase
    return {c, r};
  endfunction

  // Called at posedge+1; waits for busy to drop, then issues one request.
  task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    int         g;
    logic [W:0] e;
    exp_t       x;
    int         lat;
    g = 0;
    while (bus.busy === 1'b1) begin
      @(posedge clk); #1;
      g++;
      if (g > 4 * W + 10) begin
        chk("issue_timeout", 1, 0);
        return;
      end
    end
    bus.start = 1'b1; bus.sel = s; bus.op1 = a; bus.op2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sel = 3'($urandom); bus.op1 = W'($urandom); bus.op2 = W'($urandom);
    e     = ref_op(s, a, b);
    lat   = (s == 3'd7 || (s == 3'd3 && b != 0)) ? W : 0;
    x.out = e[W-1:0];
    x.co  = e[W];
    x.zero = (e[W-1:0] == 0);
    x.due = edge_cnt + lat;
    q.push_back(x);
    if (lat != 0) busy_end = edge_cnt + W;
  endtask

  // Start pulse while busy: must be ignored, nothing expected.
  task automatic poke(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.sel = s; bus.op1 = a; bus.op2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 4 * W + 10) begin
      @(posedge clk); #1;
      g++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(bus.busy), 64'(edge_cnt < busy_end));
      if (q.size() != 0 && edge_cnt > q[0].due) begin
        chk("missed_done", 64'(edge_cnt), 64'(q[0].due));
        void'(q.pop_front());
      end
      if (bus.done) begin
        if (bus.busy) chk("done_busy_overlap", 1, 0);
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          mon_x = q.pop_front();
          chk("out",     64'(bus.out),  64'(mon_x.out));
          chk("co",      64'(bus.co),   64'(mon_x.co));
          chk("zero",    64'(bus.zero), 64'(mon_x.zero));
          chk("latency", 64'(edge_cnt), 64'(mon_x.due));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start = 1'b0; bus.sel = '0; bus.op1 = '0; bus.op2 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out",  64'(bus.out),  0);
    chk("rst_co",   64'(bus.co),   0);
    chk("rst_zero", 64'(bus.zero), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);

    issue(3'd0, 8'd200, 8'd100); drain();
    chk("add_out", 64'(bus.out), 64'h2C);
    chk("add_co",  64'(bus.co),  1);

    issue(3'd1, 8'h00, 8'hC1);
    issue(3'd2, 8'hF0, 8'h0F); drain();
    chk("xnor_zero", 64'(bus.zero), 1);

    issue(3'd3, 8'd100, 8'd7);
    repeat (3) poke(3'd0, 8'd1, 8'd1);
    drain();
    chk("div_out", 64'(bus.out), 64'd14);

    issue(3'd3, 8'd55, 8'd0); drain();
    chk("div0_out", 64'(bus.out), 64'hFF);
    chk("div0_co",  64'(bus.co),  1);

    issue(3'd7, 8'd20, 8'd15); drain();
    chk("mul_out", 64'(bus.out), 64'h2C);

    issue(3'd7, 8'd12, 8'd10);
    issue(3'd6, 8'd0, 8'd1); drain();
    chk("neg_out", 64'(bus.out), 64'hFF);

    issue(3'd3, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    busy_end = 0;
    #1;
    chk("abort_out",  64'(bus.out),  0);
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_done", 64'(bus.done), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd5, 8'h5A, 8'h00); drain();
    chk("pass1_out", 64'(bus.out), 64'h5A);

    for (int i = 0; i < 400; i++) begin
      if (bus.busy && $urandom_range(0, 3) == 0) begin
        poke(3'($urandom), W'($urandom), W'($urandom));
      end else begin
        s = 3'($urandom);
        a = W'($urandom);
        b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk); #1;
        end
        issue(s, a, b);
      end
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 8-bit combinational ALU. It adds a start/done handshake, a configurable data width, and two multi-cycle operations: unsigned divide and unsigned multiply. Single-cycle operations complete in one clock; divide and multiply run an iterative datapath for WIDTH clocks. It sits between the register file and the writeback mux and replaces the purely combinational ALU in the execute stage.

## Interface
- WIDTH, 8, operand and result width in bits; WIDTH ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- sel  input  3  operation select; captured with start.
- op1  input  WIDTH  first operand; captured with start.
- op2  input  WIDTH  second operand; captured with start.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse: out/co/zero are valid and freshly updated.
- out  output  WIDTH  registered result; holds until the next completion.
- co  output  1  registered carry/flag; meaning depends on sel.
- zero  output  1  registered; 1 when the completed out == 0.

## Operation
- sel 000 ADD: out = (op1+op2)[WIDTH-1:0]; co = carry out of bit WIDTH-1.
- sel 001 ASHL: out = op2<<1 with LSB 0; co = op2[WIDTH-1].
- sel 010 XNOR: out = ~(op1^op2); co = 0.
- sel 011 DIV: unsigned restoring divide; out = op1/op2 quotient; remainder is discarded; co = 0.
  - Divide by zero (op2==0): out = all ones, co = 1.
- sel 100 PASS2: out = op2; co = 0.
- sel 101 PASS1: out = op1; co = 0.
- sel 110 NEG: out = (~op2)+1; co = 0.
- sel 111 MUL: unsigned shift-add multiply; out = low WIDTH bits of the product; co = 1 iff the high WIDTH bits are nonzero (overflow).
- FSM states: IDLE and RUN.
  - IDLE, start=1, single-cycle op or divide-by-zero: compute, register result, pulse done, stay IDLE.
  - IDLE, start=1, DIV with op2≠0, or MUL: latch operands, load counter = WIDTH, go to RUN, busy=1.
  - RUN: one quotient bit or one partial-product step per clock; counter decrements each clock.
  - RUN, counter reaching 0: register result, pulse done, go to IDLE.
- start while busy=1 is ignored and not queued; op1/op2/sel changes during RUN have no effect.
- zero is updated only on completion, together with out.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, counter 0, out 0, co 0, zero 0, busy 0, done 0. All outputs hold these values until the first completion.
- Reset asserted during RUN aborts immediately; no done pulse is produced.
- Single-cycle ops and divide-by-zero: start sampled at edge E0; out/co/zero update at E0; done=1 for the cycle E0→E1. Latency is 1.
- DIV (op2≠0) and MUL: start sampled at E0; busy=1 from E0 until E_WIDTH; results update at E_WIDTH; done=1 for E_WIDTH→E_WIDTH+1. Latency is WIDTH.
- done and busy are never high in the same cycle.
- start may be high during the done cycle and is accepted (back-to-back issue, no bubble). A continuous start stream of single-cycle ops produces done every cycle.
- Intermediate datapath registers are WIDTH+1 bits wide for divide and 2·WIDTH bits wide for multiply.

## Test plan
- Reset, then ADD with WIDTH=8, op1=200, op2=100 → one clock later out=0x2C, co=1, zero=0, done pulses once.
- ASHL with op2=0xC1 → out=0x82, co=1. Then XNOR with op1=0xF0, op2=0x0F → out=0x00, zero=1, co=0.
- DIV with op1=100, op2=7 → busy high for exactly 8 cycles, then out=14, co=0, done pulses one cycle. Starts issued during busy (ADD 1+1) → ignored; out never shows 2.
- DIV with op1=55, op2=0 → next cycle out=0xFF, co=1, busy never asserts.
- MUL with op1=20, op2=15 → after 8 cycles out=0x2C, co=1. MUL with 12×10 → out=120, co=0. During the done cycle, issue NEG with op2=1 → accepted; next cycle out=0xFF.
- Start DIV with 200/3, drop rst_n at cycle 4 → out=0, busy=0, no done. After release, PASS1 with op1=0x5A → out=0x5A.
